// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter
//   Shares one synchronous single-port RAM between three requesters:
//   debug/program loader (fixed top priority), CPU data port and CPU
//   instruction-fetch port (round-robin between the two CPU ports).
//   Accesses at or above RAM_SIZE are granted but not issued to the RAM,
//   and they return an error.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   dbg_req/we/addr/wdata/wstrb       debug request
//   dbg_gnt/rvalid/rdata/err          debug grant and response
//   d_req/we/addr/wdata/wstrb         CPU data request
//   d_gnt/rvalid/rdata/err            CPU data grant and response
//   i_req/addr                        CPU fetch request (read-only)
//   i_gnt/rvalid/rdata/err            CPU fetch grant and response
//   ram_en/we/addr/wdata              RAM command
//   ram_rdata                         RAM read data, one cycle after ram_en
//
// Grant is combinational in the request cycle; the response appears in
// the following cycle. Response routing state:
//   rsp_valid | a grant happened in the previous cycle
//   rsp_owner | which port that grant belonged to
//   rsp_err   | that access was out of range
//   rsp_read  | that access returns RAM data (reads, and writes with no strobes)
//   rr_last   | last CPU port granted (d or i); debug grants leave it alone

module soc_mem_arbiter #(
    parameter int unsigned RAM_SIZE = 32'h10000,
    parameter int unsigned IDX_W    = $clog2(RAM_SIZE) - 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_addr,
    input  logic [31:0]      dbg_wdata,
    input  logic [3:0]       dbg_wstrb,
    output logic             dbg_gnt,
    output logic             dbg_rvalid,
    output logic [31:0]      dbg_rdata,
    output logic             dbg_err,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    input  logic [3:0]       d_wstrb,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_err,

    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    output logic             i_err,

    output logic             ram_en,
    output logic [3:0]       ram_we,
    output logic [IDX_W-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);

    typedef enum logic [1:0] {
        OWN_DBG = 2'd0,
        OWN_D   = 2'd1,
        OWN_I   = 2'd2
    } owner_t;

    typedef enum logic {
        RR_D = 1'b0,
        RR_I = 1'b1
    } rr_t;

    rr_t         rr_last;
    owner_t      rsp_owner;
    logic        rsp_valid;
    logic        rsp_err;
    logic        rsp_read;

    logic        gnt_dbg, gnt_d, gnt_i, any_gnt;
    owner_t      owner_sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        in_range;
    logic [31:0] rsp_data;

    // Arbitration. Gated with rst_n so nothing is granted while in reset.
    always_comb begin
        gnt_dbg = rst_n & dbg_req;
        gnt_d   = rst_n & ~dbg_req & d_req & (~i_req | (rr_last == RR_I));
        gnt_i   = rst_n & ~dbg_req & i_req & (~d_req | (rr_last == RR_D));
        any_gnt = gnt_dbg | gnt_d | gnt_i;
    end

    always_comb begin
        owner_sel = OWN_I;
        sel_we    = 1'b0;
        sel_addr  = i_addr;
        sel_wdata = 32'h0;
        sel_wstrb = 4'h0;
        if (gnt_dbg) begin
            owner_sel = OWN_DBG;
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
            sel_wstrb = dbg_wstrb;
        end else if (gnt_d) begin
            owner_sel = OWN_D;
            sel_we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
            sel_wstrb = d_wstrb;
        end
    end

    assign in_range = (sel_addr < RAM_SIZE);

    // RAM command; held quiet on idle and out-of-range cycles.
    always_comb begin
        ram_en    = any_gnt & in_range;
        ram_we    = (ram_en && sel_we) ? sel_wstrb : 4'h0;
        ram_addr  = ram_en ? sel_addr[IDX_W+1:2] : '0;
        ram_wdata = ram_en ? sel_wdata : 32'h0;
    end

    always_comb begin
        dbg_gnt = gnt_dbg;
        d_gnt   = gnt_d;
        i_gnt   = gnt_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last   <= RR_I;
            rsp_valid <= 1'b0;
            rsp_owner <= OWN_DBG;
            rsp_err   <= 1'b0;
            rsp_read  <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            if (any_gnt) begin
                rsp_owner <= owner_sel;
                rsp_err   <= ~in_range;
                // A write with no byte strobes does not modify RAM and is
                // answered like a read.
                rsp_read  <= ~(sel_we & (|sel_wstrb));
            end
            if (gnt_d) begin
                rr_last <= RR_D;
            end else if (gnt_i) begin
                rr_last <= RR_I;
            end
        end
    end

    // Response routing; non-owners see all zeros.
    always_comb begin
        rsp_data   = (rsp_valid && rsp_read && !rsp_err) ? ram_rdata : 32'h0;
        dbg_rvalid = rsp_valid && (rsp_owner == OWN_DBG);
        d_rvalid   = rsp_valid && (rsp_owner == OWN_D);
        i_rvalid   = rsp_valid && (rsp_owner == OWN_I);
        dbg_err    = dbg_rvalid && rsp_err;
        d_err      = d_rvalid && rsp_err;
        i_err      = i_rvalid && rsp_err;
        dbg_rdata  = dbg_rvalid ? rsp_data : 32'h0;
        d_rdata    = d_rvalid ? rsp_data : 32'h0;
        i_rdata    = i_rvalid ? rsp_data : 32'h0;
    end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Testbench for soc_mem_arbiter with a behavioural synchronous RAM and a
// response scoreboard: every grant pushes the expected response, and a
// monitor pops and checks it in the following cycle.

module tb_soc_mem_arbiter;

    localparam int IDX_W = 14;

    logic             clk;
    logic             rst_n;
    logic             dbg_req, dbg_we;
    logic [31:0]      dbg_addr, dbg_wdata;
    logic [3:0]       dbg_wstrb;
    logic             dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0]      dbg_rdata;
    logic             d_req, d_we;
    logic [31:0]      d_addr, d_wdata;
    logic [3:0]       d_wstrb;
    logic             d_gnt, d_rvalid, d_err;
    logic [31:0]      d_rdata;
    logic             i_req;
    logic [31:0]      i_addr;
    logic             i_gnt, i_rvalid, i_err;
    logic [31:0]      i_rdata;
    logic             ram_en;
    logic [3:0]       ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;

    soc_mem_arbiter #(.RAM_SIZE(32'h10000)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .i_req(i_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, synchronous read (old data on simultaneous write).
    logic [31:0] mem [0:(1<<IDX_W)-1];
    initial begin
        for (int k = 0; k < (1 << IDX_W); k++) mem[k] = 32'h0;
        ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;   // 0 dbg, 1 d, 2 i
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input int port, input logic [31:0] rd, input logic er, input string nm);
        exp_t e;
        e.port = port; e.rdata = rd; e.err = er; e.due = cyc + 1; e.name = nm;
        sb.push_back(e);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        exp_t        e;
        logic [2:0]  exp_v, exp_e;
        logic [31:0] ed, ee, ei;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                n_cmp++; n_err++;
                $display("FAIL %s: response not seen in cycle %0d", e.name, e.due);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_v = 3'b000;
                exp_v[2 - e.port] = 1'b1;
                exp_e = e.err ? exp_v : 3'b000;
                ed = (e.port == 0) ? e.rdata : 32'h0;
                ee = (e.port == 1) ? e.rdata : 32'h0;
                ei = (e.port == 2) ? e.rdata : 32'h0;
                n_cmp++;
                if ({dbg_rvalid, d_rvalid, i_rvalid} !== exp_v ||
                    {dbg_err, d_err, i_err} !== exp_e ||
                    dbg_rdata !== ed || d_rdata !== ee || i_rdata !== ei) begin
                    n_err++;
                    $display("FAIL %s: got rvalid=%b err=%b rdata=%h/%h/%h, want rvalid=%b err=%b rdata=%h/%h/%h",
                             e.name, {dbg_rvalid, d_rvalid, i_rvalid}, {dbg_err, d_err, i_err},
                             dbg_rdata, d_rdata, i_rdata, exp_v, exp_e, ed, ee, ei);
                end
            end else begin
                n_cmp++;
                if ({dbg_rvalid, d_rvalid, i_rvalid} !== 3'b000) begin
                    n_err++;
                    $display("FAIL unexpected_rsp: got rvalid=%b in cycle %0d, want 000",
                             {dbg_rvalid, d_rvalid, i_rvalid}, cyc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_wstrb = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        i_req = 0; i_addr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        dbg_req = 1; d_req = 1; i_req = 1;
        d_addr = 32'h10; i_addr = 32'h14;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b000) begin
            n_err++; $display("FAIL rst_gnt: got %b want 000", {dbg_gnt, d_gnt, i_gnt});
        end
        n_cmp++;
        if ({dbg_rvalid, d_rvalid, i_rvalid, dbg_err, d_err, i_err} !== 6'b0) begin
            n_err++; $display("FAIL rst_rsp: got %b want 000000",
                              {dbg_rvalid, d_rvalid, i_rvalid, dbg_err, d_err, i_err});
        end
        n_cmp++;
        if (ram_en !== 1'b0 || ram_we !== 4'h0 || (dbg_rdata | d_rdata | i_rdata) !== 32'h0) begin
            n_err++; $display("FAIL rst_ram: got en=%b we=%h rdata_or=%h want 0 0 0",
                              ram_en, ram_we, dbg_rdata | d_rdata | i_rdata);
        end
        next_cycle();
        dbg_req = 0;
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b010) begin
            n_err++; $display("FAIL rst_first_tie: got %b want 010", {dbg_gnt, d_gnt, i_gnt});
        end
        push(1, 32'h0, 1'b0, "rst_d_rsp");
        next_cycle();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b001) begin
            n_err++; $display("FAIL rst_then_i: got %b want 001", {dbg_gnt, d_gnt, i_gnt});
        end
        push(2, 32'h0, 1'b0, "rst_i_rsp");
        next_cycle();
        idle_all();
    endtask

    task automatic test_debug_load();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h0; dbg_wdata = 32'h100002b7; dbg_wstrb = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (dbg_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'hF ||
            ram_addr !== 14'h0 || ram_wdata !== 32'h100002b7) begin
            n_err++; $display("FAIL dbg_write_cmd: got gnt=%b en=%b we=%h addr=%h wdata=%h want 1 1 f 0000 100002b7",
                              dbg_gnt, ram_en, ram_we, ram_addr, ram_wdata);
        end
        push(0, 32'h0, 1'b0, "dbg_write_ack");
        next_cycle();
        dbg_we = 0; dbg_wstrb = 4'h0; dbg_wdata = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (dbg_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'h0) begin
            n_err++; $display("FAIL dbg_read_cmd: got gnt=%b en=%b we=%h want 1 1 0", dbg_gnt, ram_en, ram_we);
        end
        push(0, 32'h100002b7, 1'b0, "dbg_readback");
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_d;
        d_req = 1; d_addr = 32'h0;
        i_req = 1; i_addr = 32'h4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_d = (k % 2 == 0);
            n_cmp++;
            if ({dbg_gnt, d_gnt, i_gnt} !== {1'b0, exp_d, ~exp_d}) begin
                n_err++; $display("FAIL rr_gnt_%0d: got %b want %b", k,
                                  {dbg_gnt, d_gnt, i_gnt}, {1'b0, exp_d, ~exp_d});
            end
            if (exp_d) push(1, 32'h100002b7, 1'b0, "rr_d_rsp");
            else       push(2, 32'h0, 1'b0, "rr_i_rsp");
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    task automatic test_dbg_priority();
        d_req = 1; d_addr = 32'h8;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b010) begin
            n_err++; $display("FAIL prio_d_first: got %b want 010", {dbg_gnt, d_gnt, i_gnt});
        end
        push(1, 32'h0, 1'b0, "prio_d_rsp");
        next_cycle();
        dbg_req = 1; dbg_addr = 32'h0;
        i_req = 1; i_addr = 32'hC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({dbg_gnt, d_gnt, i_gnt} !== 3'b100) begin
                n_err++; $display("FAIL prio_dbg_%0d: got %b want 100", k, {dbg_gnt, d_gnt, i_gnt});
            end
            push(0, 32'h100002b7, 1'b0, "prio_dbg_rsp");
            next_cycle();
        end
        dbg_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b001) begin
            n_err++; $display("FAIL prio_rr_held: got %b want 001", {dbg_gnt, d_gnt, i_gnt});
        end
        push(2, 32'h0, 1'b0, "prio_i_rsp");
        next_cycle();
        i_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b010) begin
            n_err++; $display("FAIL prio_d_after: got %b want 010", {dbg_gnt, d_gnt, i_gnt});
        end
        push(1, 32'h0, 1'b0, "prio_d2_rsp");
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [3];
        logic        oor   [3];
        addrs[0] = 32'h10000000; oor[0] = 1'b1;
        addrs[1] = 32'h00010000; oor[1] = 1'b1;
        addrs[2] = 32'h0000FFFC; oor[2] = 1'b0;
        d_req = 1;
        for (int k = 0; k < 3; k++) begin
            d_addr = addrs[k];
            @(negedge clk);
            n_cmp++;
            if (d_gnt !== 1'b1 || ram_en !== ~oor[k] || ram_we !== 4'h0 ||
                (!oor[k] && ram_addr !== 14'h3FFF)) begin
                n_err++; $display("FAIL oor_cmd_%h: got gnt=%b en=%b we=%h addr=%h want 1 %b 0 3fff",
                                  addrs[k], d_gnt, ram_en, ram_we, ram_addr, ~oor[k]);
            end
            push(1, 32'h0, oor[k], "oor_rsp");
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    task automatic test_byte_store();
        d_req = 1; d_we = 1; d_addr = 32'h5; d_wdata = 32'h00004800; d_wstrb = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'b0010 || ram_addr !== 14'h1) begin
            n_err++; $display("FAIL byte_store_cmd: got gnt=%b en=%b we=%b addr=%h want 1 1 0010 0001",
                              d_gnt, ram_en, ram_we, ram_addr);
        end
        push(1, 32'h0, 1'b0, "byte_store_ack");
        next_cycle();
        d_addr = 32'h4; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (d_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'b0000 || ram_addr !== 14'h1) begin
            n_err++; $display("FAIL nostrb_cmd: got gnt=%b en=%b we=%b addr=%h want 1 1 0000 0001",
                              d_gnt, ram_en, ram_we, ram_addr);
        end
        push(1, 32'h00004800, 1'b0, "nostrb_read");
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    task automatic test_mid_reset();
        i_req = 1; i_addr = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (i_gnt !== 1'b1) begin
            n_err++; $display("FAIL midrst_gnt: got %b want 1", i_gnt);
        end
        next_cycle();
        idle_all();
        rst_n = 0;
        #1;
        n_cmp++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0 || i_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_drop: got rvalid=%b rdata=%h err=%b want 0 0 0",
                              i_rvalid, i_rdata, i_err);
        end
        next_cycle();
        rst_n = 1;
        d_req = 1; d_addr = 32'h4;
        i_req = 1; i_addr = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b010) begin
            n_err++; $display("FAIL midrst_tie: got %b want 010", {dbg_gnt, d_gnt, i_gnt});
        end
        push(1, 32'h00004800, 1'b0, "midrst_d_rsp");
        next_cycle();
        d_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b001) begin
            n_err++; $display("FAIL midrst_reissue: got %b want 001", {dbg_gnt, d_gnt, i_gnt});
        end
        push(2, 32'h100002b7, 1'b0, "midrst_i_rsp");
        next_cycle();
        idle_all();
        repeat (3) next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debug_load();
        test_round_robin();
        test_dbg_priority();
        test_out_of_range();
        test_byte_store();
        test_mid_reset();
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
